// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly address sequencer for an in-place radix-2 DIT FFT over 2^N_LOG2 points.
// Optional per-stage scaling and completed-stage status are enabled by FFT_STAGE_SCALE_EN.
module fft_stage_sequencer #(
    parameter int N_LOG2   = 3,
    parameter int PIPE_LAT = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic                                    hold,
    output logic                                    busy,
    output logic                                    done,
    output logic [N_LOG2-1:0]                       stage,
    output logic                                    rd_en,
    output logic [N_LOG2-1:0]                       rd_addr_a,
    output logic [N_LOG2-1:0]                       rd_addr_b,
    output logic [((N_LOG2 > 1) ? N_LOG2-2 : 0):0]  tw_addr,
    output logic                                    dp_ready,
    output logic                                    wr_en,
    output logic [N_LOG2-1:0]                       wr_addr_a,
    output logic [N_LOG2-1:0]                       wr_addr_b,
    output logic                                    scale
);

    localparam int TW_W = (N_LOG2 > 1) ? N_LOG2 - 1 : 1;
    localparam int KW   = TW_W;
    localparam int DW   = $clog2(PIPE_LAT + 1);
    localparam logic [KW-1:0]     K_LAST = KW'((1 << (N_LOG2 - 1)) - 1);
    localparam logic [N_LOG2-1:0] S_LAST = N_LOG2'(N_LOG2 - 1);
    localparam logic [DW-1:0]     D_LAST = DW'(PIPE_LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state;
    logic [N_LOG2-1:0]  s;
    logic [KW-1:0]      k;
    logic [DW-1:0]      dcnt;

    logic [N_LOG2-1:0]  pipe_a [PIPE_LAT];
    logic [N_LOG2-1:0]  pipe_b [PIPE_LAT];
    logic [PIPE_LAT-1:0] pipe_en;

    logic [N_LOG2-1:0]  kx, low, nxt_a, nxt_b;
    logic [TW_W-1:0]    lowt, nxt_tw;

`ifdef FFT_STAGE_SCALE_EN
    logic [N_LOG2-1:0]  done_stages;
`endif

    // Butterfly k of stage s: insert a zero at bit s of k for the upper operand.
    always_comb begin
        kx     = N_LOG2'(k);
        low    = kx & ((N_LOG2'(1) << s) - N_LOG2'(1));
        nxt_a  = ((kx >> s) << (s + N_LOG2'(1))) | low;
        nxt_b  = nxt_a + (N_LOG2'(1) << s);
        lowt   = TW_W'(low);
        nxt_tw = lowt << (N_LOG2'(N_LOG2 - 1) - s);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            s         <= '0;
            k         <= '0;
            dcnt      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            stage     <= '0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
`ifdef FFT_STAGE_SCALE_EN
            done_stages <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    stage <= '0;
                    rd_en <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        s     <= '0;
                        k     <= '0;
`ifdef FFT_STAGE_SCALE_EN
                        done_stages <= '0;
`endif
                    end
                end
                RUN: begin
                    busy  <= 1'b1;
                    stage <= s;
                    if (hold) begin
                        rd_en <= 1'b0;
                    end else begin
                        rd_en     <= 1'b1;
                        rd_addr_a <= nxt_a;
                        rd_addr_b <= nxt_b;
                        tw_addr   <= nxt_tw;
                        if (k == K_LAST) begin
                            state <= DRAIN;
                            dcnt  <= '0;
                        end else begin
                            k <= k + KW'(1);
                        end
                    end
                end
                DRAIN: begin
                    busy  <= 1'b1;
                    stage <= s;
                    rd_en <= 1'b0;
                    if (dcnt == D_LAST) begin
`ifdef FFT_STAGE_SCALE_EN
                        if (done_stages != N_LOG2'(N_LOG2))
                            done_stages <= done_stages + N_LOG2'(1);
`endif
                        if (s == S_LAST) begin
                            state <= DONE;
                        end else begin
                            s     <= s + N_LOG2'(1);
                            k     <= '0;
                            state <= RUN;
                        end
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    rd_en <= 1'b0;
`ifdef FFT_STAGE_SCALE_EN
                    stage <= done_stages;
`else
                    stage <= '0;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write-back delay lines; cleared on reset so in-flight butterflies never write.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_en <= '0;
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                pipe_a[i] <= '0;
                pipe_b[i] <= '0;
            end
        end else begin
            pipe_en   <= {pipe_en[PIPE_LAT-2:0], rd_en};
            pipe_a[0] <= rd_addr_a;
            pipe_b[0] <= rd_addr_b;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                pipe_a[i] <= pipe_a[i-1];
                pipe_b[i] <= pipe_b[i-1];
            end
        end
    end

    assign dp_ready  = pipe_en[0];
    assign wr_en     = pipe_en[PIPE_LAT-1];
    assign wr_addr_a = pipe_a[PIPE_LAT-1];
    assign wr_addr_b = pipe_b[PIPE_LAT-1];

`ifdef FFT_STAGE_SCALE_EN
    always_ff @(posedge clk) begin
        if (reset) scale <= 1'b0;
        else       scale <= rd_en;
    end
`else
    assign scale = 1'b0;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer (N_LOG2=3, PIPE_LAT=2): scenario table plus
// butterfly scoreboard, with hand-written reset-abort and start-repulse sequences.
module tb_fft_stage_sequencer;

    localparam int N_LOG2   = 3;
    localparam int PIPE_LAT = 2;
    localparam int NPTS     = 8;
    localparam int HALF     = 4;
`ifdef FFT_STAGE_SCALE_EN
    localparam bit SCALE_ON = 1'b1;
`else
    localparam bit SCALE_ON = 1'b0;
`endif
    localparam int DONE_STAGE = SCALE_ON ? N_LOG2 : 0;

    logic clk = 1'b0;
    logic reset, start, hold;
    logic busy, done, rd_en, dp_ready, wr_en, scale;
    logic [N_LOG2-1:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [N_LOG2-2:0] tw_addr;

    always #5 clk = ~clk;

    fft_stage_sequencer #(.N_LOG2(N_LOG2), .PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .hold(hold),
        .busy(busy), .done(done), .stage(stage),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
        .dp_ready(dp_ready), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .scale(scale)
    );

    typedef struct { int cyc; int a; int b; int tw; int stg; } bfly_t;
    typedef struct { int hold_lo; int hold_hi; bit repulse; int exp_done; } scen_t;

    int checks = 0;
    int errors = 0;
    bfly_t rdq[$];
    bfly_t wrq[$];
    bit exp_rd [0:79];
    int exp_stg [0:79];
    scen_t scen [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".busy"},      int'(busy), 0);
        chk({tag, ".done"},      int'(done), 0);
        chk({tag, ".stage"},     int'(stage), 0);
        chk({tag, ".rd_en"},     int'(rd_en), 0);
        chk({tag, ".rd_addr_a"}, int'(rd_addr_a), 0);
        chk({tag, ".rd_addr_b"}, int'(rd_addr_b), 0);
        chk({tag, ".tw_addr"},   int'(tw_addr), 0);
        chk({tag, ".dp_ready"},  int'(dp_ready), 0);
        chk({tag, ".wr_en"},     int'(wr_en), 0);
        chk({tag, ".wr_addr_a"}, int'(wr_addr_a), 0);
        chk({tag, ".wr_addr_b"}, int'(wr_addr_b), 0);
        chk({tag, ".scale"},     int'(scale), 0);
    endtask

    // Expected issue schedule, enumerated group-by-group; holds only delay issue slots.
    task automatic build_expect(input int hlo, input int hhi);
        int cyc;
        cyc = 1;
        rdq.delete();
        wrq.delete();
        for (int i = 0; i < 80; i++) begin
            exp_rd[i]  = 1'b0;
            exp_stg[i] = 0;
        end
        for (int s = 0; s < N_LOG2; s++) begin
            int span;
            span = 1 << s;
            for (int g = 0; g < NPTS / (2 * span); g++) begin
                for (int j = 0; j < span; j++) begin
                    bfly_t e;
                    while (cyc >= hlo && cyc <= hhi) begin
                        exp_stg[cyc] = s;
                        cyc++;
                    end
                    e.cyc = cyc;
                    e.a   = g * 2 * span + j;
                    e.b   = e.a + span;
                    e.tw  = j * (HALF / span);
                    e.stg = s;
                    rdq.push_back(e);
                    e.cyc = cyc + PIPE_LAT;
                    wrq.push_back(e);
                    exp_rd[cyc]  = 1'b1;
                    exp_stg[cyc] = s;
                    cyc++;
                end
            end
            for (int d = 0; d < PIPE_LAT; d++) begin
                exp_stg[cyc] = s;
                cyc++;
            end
        end
    endtask

    task automatic cycle_checks(input int c, input int dn);
        bfly_t e;
        int exp_stage;
        chk($sformatf("rd_en@%0d", c),    int'(rd_en),    int'(exp_rd[c]));
        chk($sformatf("dp_ready@%0d", c), int'(dp_ready), int'(exp_rd[c-1]));
        chk($sformatf("wr_en@%0d", c),    int'(wr_en),    (c >= PIPE_LAT) ? int'(exp_rd[c-PIPE_LAT]) : 0);
        chk($sformatf("busy@%0d", c),     int'(busy),     (c < dn) ? 1 : 0);
        chk($sformatf("done@%0d", c),     int'(done),     (c == dn) ? 1 : 0);
        exp_stage = (c < dn) ? exp_stg[c] : ((c == dn) ? DONE_STAGE : 0);
        chk($sformatf("stage@%0d", c),    int'(stage),    exp_stage);
        chk($sformatf("scale@%0d", c),    int'(scale),    SCALE_ON ? int'(exp_rd[c-1]) : 0);
        if (rd_en) begin
            if (rdq.size() == 0) begin
                chk($sformatf("rd_unexpected@%0d", c), 1, 0);
            end else begin
                e = rdq.pop_front();
                chk($sformatf("rd_cycle s%0d", e.stg), c, e.cyc);
                chk($sformatf("rd_addr_a@%0d", c), int'(rd_addr_a), e.a);
                chk($sformatf("rd_addr_b@%0d", c), int'(rd_addr_b), e.b);
                chk($sformatf("tw_addr@%0d", c),   int'(tw_addr),   e.tw);
            end
        end
        if (wr_en) begin
            if (wrq.size() == 0) begin
                chk($sformatf("wr_unexpected@%0d", c), 1, 0);
            end else begin
                e = wrq.pop_front();
                chk($sformatf("wr_cycle s%0d", e.stg), c, e.cyc);
                chk($sformatf("wr_addr_a@%0d", c), int'(wr_addr_a), e.a);
                chk($sformatf("wr_addr_b@%0d", c), int'(wr_addr_b), e.b);
            end
        end
    endtask

    // Cycle n = outputs after the n-th rising edge; start is sampled at edge 0.
    task automatic run_scenario(input scen_t sc);
        int last;
        int done_at;
        build_expect(sc.hold_lo, sc.hold_hi);
        last = sc.repulse ? sc.exp_done : sc.exp_done + PIPE_LAT + 1;
        @(negedge clk);
        start = 1'b1;
        hold  = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        hold  = (1 >= sc.hold_lo && 1 <= sc.hold_hi);
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            cycle_checks(c, sc.exp_done);
            hold  = (c + 1 >= sc.hold_lo && c + 1 <= sc.hold_hi);
            start = sc.repulse && (c + 1 == 5 || c + 1 == 19 || c + 1 == 20);
        end
        hold = 1'b0;
        if (sc.repulse) begin
            @(posedge clk); #1;
            start = 1'b0;
            chk("repulse.busy@20", int'(busy), 0);
            chk("repulse.done@20", int'(done), 0);
            @(posedge clk); #1;
            chk("repulse.busy@21", int'(busy), 1);
            chk("repulse.stage@21", int'(stage), 0);
            done_at = -1;
            for (int n = 22; n <= 80; n++) begin
                @(posedge clk); #1;
                if (done) begin
                    done_at = n;
                    break;
                end
            end
            chk("repulse.done_cycle", done_at, 39);
            @(posedge clk); #1;
            chk("repulse.idle_busy", int'(busy), 0);
        end
        chk("rd_queue_left", rdq.size(), 0);
        chk("wr_queue_left", wrq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        hold  = 1'b0;
        scen[0] = '{hold_lo: 0,  hold_hi: -1, repulse: 1'b0, exp_done: 19};
        scen[1] = '{hold_lo: 2,  hold_hi: 3,  repulse: 1'b0, exp_done: 21};
        scen[2] = '{hold_lo: 5,  hold_hi: 6,  repulse: 1'b0, exp_done: 19};
        scen[3] = '{hold_lo: 16, hold_hi: 16, repulse: 1'b0, exp_done: 20};
        scen[4] = '{hold_lo: 1,  hold_hi: 1,  repulse: 1'b0, exp_done: 20};
        scen[5] = '{hold_lo: 0,  hold_hi: -1, repulse: 1'b1, exp_done: 19};

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_scenario(scen[i]);

        // Abort with a butterfly in flight: issued at cycle 7, reset sampled at edge 8.
        build_expect(0, -1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            cycle_checks(c, 19);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_zero("abort@8");
        @(posedge clk); #1;
        check_zero("abort@9");
        run_scenario(scen[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Sequences an in-place radix-2 DIT FFT over N = 2^N_LOG2 complex points held in a dual-port sample RAM.
- Each stage walks every butterfly and issues the read addresses for both operands plus the twiddle ROM address.
- Drives the ready/enable of the registered complex add/sub/multiply datapath, then issues delayed write-back addresses.
- Sits between the top-level FFT control (start/done) and the butterfly datapath/memories.

Parameters:
- N_LOG2, 3, log2 of transform length; legal range 1..12.
- PIPE_LAT, 2, cycles from read issue to write-back (RAM read + datapath register stages); minimum 2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin transform; sampled only in IDLE
- hold  in  1  stall butterfly issue this cycle
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  single-cycle completion pulse
- stage  out  N_LOG2  index of the stage currently issuing or draining
- rd_en  out  1  read/issue strobe for one butterfly
- rd_addr_a  out  N_LOG2  upper operand address
- rd_addr_b  out  N_LOG2  lower operand address
- tw_addr  out  N_LOG2-1  twiddle ROM index (width max(1, N_LOG2-1))
- dp_ready  out  1  datapath enable; rd_en delayed 1 cycle
- wr_en  out  1  write-back strobe; rd_en delayed PIPE_LAT cycles
- wr_addr_a  out  N_LOG2  rd_addr_a delayed PIPE_LAT
- wr_addr_b  out  N_LOG2  rd_addr_b delayed PIPE_LAT
- scale  out  1  see Optional Feature; tied 0 when compiled out

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. Every output is registered.
- Reset values: state IDLE, stage=0, k=0. All outputs 0, and every delay-line entry is cleared.
- Reset mid-transform: aborts immediately. No wr_en pulse may follow reset, including from butterflies already in flight.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 → RUN, with stage=0, k=0, busy=1 from the next cycle.
- Start outside IDLE: ignored.
- RUN, per cycle with hold=0: assert rd_en and issue butterfly k of the current stage s.
  - span = 2^s
  - rd_addr_a = ((k >> s) << (s+1)) | (k & (span-1))
  - rd_addr_b = rd_addr_a + span
  - tw_addr = (k & (span-1)) << (N_LOG2-1-s)
  - k then increments.
- RUN with hold=1: rd_en=0, addresses hold their last values, k unchanged. The delay lines keep shifting, so bubbles propagate.
- RUN → DRAIN: after issuing k = N/2-1.
- DRAIN: counts PIPE_LAT cycles with no issue, so the last write of a stage lands before the next stage reads (in-place RAW hazard). hold is ignored in DRAIN.
- DRAIN exit:
  - s < N_LOG2-1 → RUN, with s+1 and k=0.
  - otherwise → DONE.
- DONE: done=1 for exactly 1 cycle, busy=0 in the same cycle, then → IDLE.
- stage output is valid throughout RUN and DRAIN; it returns to 0 in IDLE.
- Timing with no hold: each stage takes N/2 + PIPE_LAT cycles. done is asserted N_LOG2*(N/2+PIPE_LAT)+1 cycles after the cycle start was sampled.
- Simultaneous events: reset has priority over start and hold. In the DONE cycle, start is ignored; it is accepted from IDLE on the next cycle.

Optional Feature:
- Macro: FFT_STAGE_SCALE_EN.
- With it defined: scale is driven high alongside dp_ready on every butterfly, so the datapath applies a divide-by-2 (arithmetic shift right 1) per stage to prevent 16-bit overflow.
- Also with it defined: a status register counts completed stages and saturates at N_LOG2. It is readable as stage while in DONE.
- Without it: scale is constant 0, no counter is generated, and stage reads 0 in DONE.

Test Plan:
- N_LOG2=3, PIPE_LAT=2, pulse start at cycle 0, hold=0 → rd_en high cycles 1-4, 7-10 and 13-16; done high at cycle 19 only; busy high cycles 1-18.
- Same config, address check:
  - stage 0, k=3 → a=6, b=7, tw=0.
  - stage 1, k=1 → a=1, b=3, tw=2.
  - stage 2, k=3 → a=3, b=7, tw=3.
  - wr_addr values equal the rd_addr values exactly 2 cycles later.
- hold=1 on cycles 2-3 during stage 0 → rd_en low on those cycles, k=1 issued at cycle 4, wr_en gaps shifted 2 cycles later, done at cycle 21.
- reset asserted at cycle 8, with a butterfly issued at cycle 7 → no wr_en at cycle 9; all outputs 0 from cycle 9; a subsequent start restarts at stage 0, k=0.
- start re-pulsed at cycles 5 and 19 → both ignored, no restart; start at cycle 20 accepted, busy=1 at cycle 21.
- FFT_STAGE_SCALE_EN defined → scale equals dp_ready on all 12 butterflies; stage reads 3 in the DONE cycle. Without the macro, scale stays 0 throughout.
